// File: rtl/nios_upc_pio_pkg.sv
// rtl/nios_upc_pio_pkg.sv - shared constants for the Nios II input PIO conditioning wrappers
package nios_upc_pio_pkg;

    // Width of the board-facing input PIO.
    localparam int NIOS_UPC_PIO_WIDTH = 8;

    // 1 ms at 50 MHz.
    localparam int NIOS_UPC_DEBOUNCE_DEFAULT = 50000;

    // Wide enough to hold NIOS_UPC_DEBOUNCE_DEFAULT - 1.
    localparam int NIOS_UPC_CNT_WIDTH = 16;

    // Per-bit filter outputs gathered in one place for the top-level fan-in.
    typedef struct packed {
        logic db;
        logic rise;
        logic fall;
        logic settled;
    } nios_upc_db_bit_t;

    // Count value at which a differing sample has been stable long enough.
    function automatic int nios_upc_terminal_count(input int debounce_cycles);
        return debounce_cycles - 1;
    endfunction

endpackage

// File: rtl/nios_upc_debounce_bit.sv
// rtl/nios_upc_debounce_bit.sv - one bit: 2-flop sync, saturating debounce counter, edge strobes (NIOS_UPC_DEBOUNCE_ACTIVE_LOW_EN)
module nios_upc_debounce_bit
    import nios_upc_pio_pkg::*;
#(
    parameter int CNT_WIDTH       = NIOS_UPC_CNT_WIDTH,
    parameter int DEBOUNCE_CYCLES = NIOS_UPC_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic settled
);

    localparam logic [CNT_WIDTH-1:0] CNT_TERMINAL =
        CNT_WIDTH'(nios_upc_terminal_count(DEBOUNCE_CYCLES));

    // The sync flops hold the raw pad polarity so they can reset to the pad's
    // idle level; the inversion is applied on the way out of the synchronizer.
`ifdef NIOS_UPC_DEBOUNCE_ACTIVE_LOW_EN
    localparam logic SYNC_RESET_LEVEL = 1'b1;
    localparam logic SAMPLE_INVERT    = 1'b1;
`else
    localparam logic SYNC_RESET_LEVEL = 1'b0;
    localparam logic SAMPLE_INVERT    = 1'b0;
`endif

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic                 db_q, db_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 sample;

    assign sample = s2_q ^ SAMPLE_INVERT;

    // Synchronizer shift and debounce filter next-state.
    always_comb begin
        s1_d   = raw_in;
        s2_d   = s1_q;
        db_d   = db_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sample == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_TERMINAL) begin
            db_d   = sample;
            cnt_d  = '0;
            rise_d = sample;
            fall_d = ~sample;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset discards any count in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= SYNC_RESET_LEVEL;
            s2_q   <= SYNC_RESET_LEVEL;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign settled    = (cnt_q == '0) && (sample == db_q);

endmodule

// File: rtl/nios_upc_input_debounce.sv
// rtl/nios_upc_input_debounce.sv - per-bit debounce and edge strobes ahead of the Nios II input PIO (NIOS_UPC_DEBOUNCE_ACTIVE_LOW_EN)
module nios_upc_input_debounce
    import nios_upc_pio_pkg::*;
#(
    parameter int WIDTH           = NIOS_UPC_PIO_WIDTH,
    parameter int CNT_WIDTH       = NIOS_UPC_CNT_WIDTH,
    parameter int DEBOUNCE_CYCLES = NIOS_UPC_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             settled
);

    nios_upc_db_bit_t bit_status [WIDTH];
    logic [WIDTH-1:0] settled_bits;

    // Bits are fully independent filters sharing only clock and reset.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_upc_debounce_bit #(
            .CNT_WIDTH       (CNT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw_in     (raw_in[i]),
            .db_out     (bit_status[i].db),
            .rise_pulse (bit_status[i].rise),
            .fall_pulse (bit_status[i].fall),
            .settled    (bit_status[i].settled)
        );

        assign db_out[i]       = bit_status[i].db;
        assign rise_pulse[i]   = bit_status[i].rise;
        assign fall_pulse[i]   = bit_status[i].fall;
        assign settled_bits[i] = bit_status[i].settled;
    end

    // Quiet only when every bit is idle.
    assign settled = &settled_bits;

endmodule
